// File: rtl/vga_pattern_gen.sv
// VGA test-pattern burst generator: streams one frame of RGB565 words
// per accepted start pulse, paced by the memory-side wr_en handshake.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int LINES    = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic        wr_en,
  output logic        data_en,
  output logic [15:0] dout,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  frame_cnt_o,
  output logic        overrun_o
);

  localparam int N   = H_ACTIVE * LINES;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int BAR = H_ACTIVE / 8;
  localparam int BW  = (BAR > 1) ? $clog2(BAR) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [10:0]     x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bar_q, bar_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            data_en_q, data_en_d;
  logic [15:0]     dout_q, dout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      frame_q, frame_d;
  logic            ovr_q, ovr_d;

  logic [15:0]     bar_rgb;
  logic [15:0]     pix;
  logic            x_last;
  logic            bcnt_last;
  logic            cnt_last;

  assign x_last    = (x_q == 11'(H_ACTIVE - 1));
  assign bcnt_last = (bcnt_q == BW'(BAR - 1));
  assign cnt_last  = (cnt_q == CW'(N - 1));

  always_comb begin
    bar_rgb = 16'h0000;
    unique case (bar_q)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  always_comb begin
    pix = 16'h0000;
    unique case (mode_q)
      2'd0:    pix = bar_rgb;
      2'd1:    pix = {x_q[9:5], y_q[5:0], frame_q[4:0]};
      2'd2:    pix = (x_q[4] ^ y_q[4]) ? 16'hFFFF : 16'h0000;
      default: pix = {frame_q[4:0], 6'h00, ~frame_q[4:0]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    bar_d     = bar_q;
    bcnt_d    = bcnt_q;
    data_en_d = 1'b0;
    dout_d    = dout_q;
    done_d    = 1'b0;
    frame_d   = frame_q;
    ovr_d     = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          mode_d  = mode_i;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          bar_d   = '0;
          bcnt_d  = '0;
        end
      end
      RUN: begin
        if (start_i) ovr_d = 1'b1;
        if (wr_en) begin
          data_en_d = 1'b1;
          dout_d    = pix;
          cnt_d     = cnt_q + 1'b1;
          if (x_last) begin
            x_d    = '0;
            y_d    = y_q + 8'd1;
            bar_d  = '0;
            bcnt_d = '0;
          end else begin
            x_d = x_q + 11'd1;
            if (bcnt_last) begin
              bcnt_d = '0;
              bar_d  = bar_q + 3'd1;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
          if (cnt_last) state_d = DONE;
        end
      end
      DONE: begin
        if (start_i) ovr_d = 1'b1;
        done_d  = 1'b1;
        frame_d = frame_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      bar_q     <= '0;
      bcnt_q    <= '0;
      data_en_q <= 1'b0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      frame_q   <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      bar_q     <= bar_d;
      bcnt_q    <= bcnt_d;
      data_en_q <= data_en_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      frame_q   <= frame_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_en     = data_en_q;
  assign dout        = dout_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_cnt_o = frame_q;
  assign overrun_o   = ovr_q;

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1024, pixels per line (multiple of 8, at most 2047).
REQ-002 The block SHALL have parameter LINES, default 40, lines per frame burst; frame word count N = H_ACTIVE*LINES.
REQ-003 The block SHALL have port clk, input, 1, single clock for all logic (50 MHz write-side clock).
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1, frame-sync pulse requesting one frame burst.
REQ-006 The block SHALL have port mode_i, input, 2, pattern select, sampled on accepted start_i.
REQ-007 The block SHALL have port wr_en, input, 1, memory-side ready-to-accept write data.
REQ-008 The block SHALL have port data_en, output, 1, write strobe: dout valid this cycle.
REQ-009 The block SHALL have port dout, output, 16, RGB565 pixel word {R[4:0],G[5:0],B[4:0]}.
REQ-010 The block SHALL have port busy_o, output, 1, high while in RUN.
REQ-011 The block SHALL have port done_o, output, 1, one-cycle pulse after the last word of a burst.
REQ-012 The block SHALL have port frame_cnt_o, output, 8, count of completed bursts, wraps 255->0.
REQ-013 The block SHALL have port overrun_o, output, 1, sticky flag: start_i arrived while busy.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; all outputs SHALL be registered.
REQ-015 IDLE + start_i=1 -> RUN next cycle; SHALL latch mode_i and clear x (11 bit), y (8 bit), word count.
REQ-016 In RUN, each edge with wr_en=1 SHALL issue one word: data_en=1 next cycle with dout for current (x,y), then x increments.
REQ-017 In RUN, wr_en=0 SHALL give data_en=0 next cycle with x, y, count held; dout holds its last value.
REQ-018 x reaching H_ACTIVE-1 on an issued word SHALL wrap x to 0 and increment y.
REQ-019 The issue of word N-1 SHALL move RUN->DONE; no further words SHALL issue even if wr_en stays high.
REQ-020 DONE SHALL last exactly one cycle: done_o=1, frame_cnt_o increments, then IDLE.
REQ-021 start_i in RUN or DONE SHALL be ignored for sequencing and SHALL set overrun_o; only rst clears it.
REQ-022 start_i and wr_en are both sampled in IDLE; the first word SHALL issue no earlier than the first RUN cycle.
REQ-023 Mode 0, colour bars: bar = x/(H_ACTIVE/8) via a bar counter (no divider), colours in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-024 Mode 1, gradient: dout SHALL be {x[9:5], y[5:0], frame_cnt_o[4:0]}.
REQ-025 Mode 2, checkerboard: dout SHALL be FFFF when x[4]^y[4]=1, else 0000.
REQ-026 Mode 3, solid: dout SHALL be {frame_cnt_o[4:0], 6'h00, ~frame_cnt_o[4:0]}, constant across the burst.
REQ-027 mode_i changes during RUN SHALL have no effect until the next accepted start_i.
REQ-028 Exactly N data_en pulses SHALL occur per accepted start_i when no reset occurs mid-burst.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and, from the next cycle, data_en=0, dout=0000, busy_o=0, done_o=0, frame_cnt_o=0, overrun_o=0, x=y=count=0, latched mode=0.
REQ-030 rst mid-burst SHALL abort the burst with no done_o; the next start_i SHALL restart at pixel (0,0).
REQ-031 rst SHALL dominate start_i and wr_en in the same cycle.

Verification
REQ-032 Reset, start_i (mode 0), wr_en held 1, H_ACTIVE=1024, LINES=40 -> 40960 contiguous data_en; word 0=FFFF, word 128=FFE0, word 1023=0000, word 1024=FFFF; done_o once; frame_cnt_o=1.
REQ-033 Mode 2, wr_en toggled 1,0,1,0 -> data_en mirrors wr_en one cycle late; words 15, 16, 1040 = 0000, FFFF, FFFF.
REQ-034 Second start_i pulse mid-burst -> overrun_o=1; total data_en still 40960; exactly one done_o.
REQ-035 rst after 500 words, then start_i mode 3 -> outputs at reset values; burst restarts at (0,0); all words 001F with frame_cnt_o=0.
REQ-036 Mode 1, two back-to-back bursts -> second burst word at x=1023,y=39 equals {5'h1F, 6'h27, 5'h01}; frame_cnt_o=2 at end.
REQ-037 255+1 completed bursts (LINES reduced to 1) -> frame_cnt_o wraps 255->0.
